// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module   : serial_adder_pkg
// Brief    : Shared constants and full-adder helper functions for serial_adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam int C_DEFAULT_WIDTH = 4;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (ci & (x ^ y));
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
// ============================================================================
// Module   : serial_adder_full_adder
// Brief    : One-bit combinational full adder cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder_full_adder
  import serial_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = fa_sum(x, y, ci);
  assign co = fa_carry(x, y, ci);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial unsigned adder, LSB-first, one bit per shift cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cout;
  logic             r_done;
  logic             w_s;
  logic             w_co;

  serial_adder_full_adder u_fa (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else if (shift && !r_done) begin
      // New bit enters at the MSB so the first bit lands at sum[0] after WIDTH shifts
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_co;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (r_cnt == c_last) begin
        r_done <= 1'b1;
        r_cout <= w_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Self-checking bench for serial_adder against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic         shift = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] sum;
  logic         cout;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  // Model: latched operands and number of bits processed since load/reset
  int m_a = 0;
  int m_b = 0;
  int m_k = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Partial sum: low k bits of (A+B) restricted to the low k operand bits,
  // sitting in the top k positions of the sum register.
  task automatic check_model();
    int mask;
    int part;
    int es;
    int ed;
    int ec;
    mask = (1 << m_k) - 1;
    part = ((m_a & mask) + (m_b & mask)) & mask;
    es   = (part << (W - m_k)) & ((1 << W) - 1);
    ed   = (m_k == W) ? 1 : 0;
    ec   = ed ? (((m_a + m_b) >> W) & 1) : 0;
    chk("model_sum", int'(sum), es);
    chk("model_done", int'(done), ed);
    chk("model_cout", int'(cout), ec);
  endtask

  task automatic step(input logic rs, input logic ld, input logic sh,
                      input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    reset = rs;
    load  = ld;
    shift = sh;
    a     = av;
    b     = bv;
    @(posedge clk);
    if (rs) begin
      m_a = 0; m_b = 0; m_k = 0;
    end else if (ld) begin
      m_a = int'(av); m_b = int'(bv); m_k = 0;
    end else if (sh && m_k < W) begin
      m_k++;
    end
    #1;
    check_model();
  endtask

  task automatic do_load(input logic [W-1:0] av, input logic [W-1:0] bv);
    step(1'b0, 1'b1, 1'b0, av, bv);
  endtask

  task automatic do_shifts(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    // Reset and idle
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_done", int'(done), 0);
    do_idle(2);
    do_shifts(2);
    chk("noload_sum", int'(sum), 0);

    // 12 + 7 = 19 -> sum 3, cout 1; extra shifts are ignored
    do_load(4'b1100, 4'b0111);
    do_shifts(4);
    chk("a12b7_sum", int'(sum), 3);
    chk("a12b7_cout", int'(cout), 1);
    chk("a12b7_done", int'(done), 1);
    do_shifts(3);
    chk("a12b7_hold_sum", int'(sum), 3);
    chk("a12b7_hold_cout", int'(cout), 1);

    // 5 + 3 with a pause after bit 2
    do_load(4'd5, 4'd3);
    do_shifts(2);
    do_idle(2);
    do_shifts(1);
    chk("a5b3_done_early", int'(done), 0);
    do_shifts(1);
    chk("a5b3_done", int'(done), 1);
    chk("a5b3_sum", int'(sum), 8);
    chk("a5b3_cout", int'(cout), 0);

    // Boundaries: wrap to zero, and all-zero operands
    do_load(4'hF, 4'h1);
    do_shifts(4);
    chk("aFb1_sum", int'(sum), 0);
    chk("aFb1_cout", int'(cout), 1);
    do_load(4'h0, 4'h0);
    do_shifts(4);
    chk("a0b0_sum", int'(sum), 0);
    chk("a0b0_cout", int'(cout), 0);

    // Load dominates shift
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 4'd6, 4'd7);
    chk("ldsh_done", int'(done), 0);
    chk("ldsh_sum", int'(sum), 0);
    do_shifts(3);
    chk("ldsh_done_early", int'(done), 0);
    do_shifts(1);
    chk("ldsh_done_final", int'(done), 1);
    chk("ldsh_sum_final", int'(sum), 13);

    // Reset mid-operation, then a clean reload
    do_load(4'h9, 4'h9);
    do_shifts(2);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    chk("abort_sum", int'(sum), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_cout", int'(cout), 0);
    do_load(4'h9, 4'h9);
    do_shifts(4);
    chk("a9b9_sum", int'(sum), 2);
    chk("a9b9_cout", int'(cout), 1);

    // Random mix of reset/load/shift/idle
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3)
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             W'($urandom), W'($urandom));
      else if (r < 18)
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
      else if (r < 80)
        step(1'b0, 1'b0, 1'b1, W'($urandom), W'($urandom));
      else
        step(1'b0, 1'b0, 1'b0, W'($urandom), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
